// File: rtl/progmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// progmem_arbiter_if
// Avalon-style read-only memory port bundle shared by the requesters and by
// the program memory side of progmem_arbiter.
//
// Signals:
//   address      request address (ADDR_W)
//   read         read strobe; held by the master until waitrequest is low
//   readdata     read data (DATA_W), valid in the cycle waitrequest is low
//   response     2'b00 OKAY, 2'b10 SLVERR
//   waitrequest  stall from the slave side
//
// Modports:
//   master  drives address/read, receives readdata/response/waitrequest
//   slave   receives address/read, drives readdata/response/waitrequest
// -----------------------------------------------------------------------------
interface progmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic [1:0]        response;
    logic              waitrequest;

    modport master (
        output address, read,
        input  readdata, response, waitrequest
    );

    modport slave (
        input  address, read,
        output readdata, response, waitrequest
    );
endinterface

// File: rtl/progmem_arbiter.sv
// -----------------------------------------------------------------------------
// progmem_arbiter
// Shares one read-only program memory port between two requesters
// (m0: DSI command sequencer fetch, m1: host debug/readback). Round-robin
// arbitration, one outstanding access at a time, fully registered outputs,
// and an optional slave timeout that turns a hung access into SLVERR.
//
// Handshake: a master holds read (and address) until it sees waitrequest low;
// the arbiter drops that master's waitrequest for exactly one cycle per
// completed access, with readdata/response valid in that cycle. Toward the
// memory, s.read is held until s.waitrequest is sampled low (or timeout).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   m0, m1       requester ports (slave modport of progmem_arbiter_if)
//   s            program memory port (master modport of progmem_arbiter_if)
//   o_dbg_state  current FSM state (0 IDLE, 1 REQ, 2 RESP)
// -----------------------------------------------------------------------------
module progmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    progmem_arbiter_if.slave         m0,
    progmem_arbiter_if.slave         m1,
    progmem_arbiter_if.master        s,
    output logic [1:0]               o_dbg_state
);

    // A zero TIMEOUT disables the timeout; keep a 1-bit counter so the
    // declarations stay legal.
    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             TO_EN    = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_grant;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_s_address;
    logic              r_s_read;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_resp;
    logic              r_m0_wait;
    logic              r_m1_wait;

    logic              w_any;
    logic              w_pick;
    logic              w_done;
    logic              w_timeout;
    logic              w_grant_nxt;
    logic              w_last_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic [1:0]        w_resp_nxt;

    assign w_any     = m0.read | m1.read;
    // On a tie the requester that did not win last time gets the port.
    assign w_pick    = (m0.read & m1.read) ? ~r_last_grant : ~m0.read;
    assign w_done    = (r_state == ST_REQ) & ~s.waitrequest;
    assign w_timeout = (r_state == ST_REQ) & s.waitrequest & TO_EN & (r_cnt == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_s_address  <= '0;
            r_s_read     <= 1'b0;
            r_rdata      <= '0;
            r_resp       <= 2'b00;
            r_m0_wait    <= 1'b1;
            r_m1_wait    <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_s_address  <= w_addr_nxt;
            // Outputs are registered from the next state so they line up
            // with the state they belong to.
            r_s_read     <= (w_next_state == ST_REQ);
            r_rdata      <= w_rdata_nxt;
            r_resp       <= w_resp_nxt;
            r_m0_wait    <= ~((w_next_state == ST_RESP) & ~r_grant);
            r_m1_wait    <= ~((w_next_state == ST_RESP) &  r_grant);
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next_state = ST_REQ;
            ST_REQ:  if (w_done || w_timeout) w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_s_address;
        w_rdata_nxt = r_rdata;
        w_resp_nxt  = r_resp;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_addr_nxt  = w_pick ? m1.address : m0.address;
                    w_cnt_nxt   = '0;
                end
            end
            ST_REQ: begin
                if (w_done) begin
                    w_rdata_nxt = s.readdata;
                    w_resp_nxt  = s.response;
                    w_last_nxt  = r_grant;
                end else if (w_timeout) begin
                    w_rdata_nxt = '0;
                    w_resp_nxt  = 2'b10;
                    w_last_nxt  = r_grant;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign s.address      = r_s_address;
    assign s.read         = r_s_read;
    // Captured data is shared; only the granted master sees waitrequest low.
    assign m0.readdata    = r_rdata;
    assign m0.response    = r_resp;
    assign m0.waitrequest = r_m0_wait;
    assign m1.readdata    = r_rdata;
    assign m1.response    = r_resp;
    assign m1.waitrequest = r_m1_wait;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_progmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_progmem_arbiter
// Self-checking bench for progmem_arbiter. dut_a (TIMEOUT=8) serves two
// queued requester drivers and a latency-programmable memory model; dut_z
// (TIMEOUT=0) checks a long-latency access without timeout.
// -----------------------------------------------------------------------------
module tb_progmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  abort;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  req_t        req_q[2][$];
  logic [33:0] exp_q[2][$];
  logic [31:0] sa_log[$];
  int          len_log[$];
  int          done_cnt[2];
  int          drop_cnt[2];
  int          lat_last[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A (TIMEOUT = 8) ----------------
  progmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_m[2] ();
  progmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_s ();
  logic [1:0] a_state;

  progmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .m0(a_m[0]), .m1(a_m[1]), .s(a_s), .o_dbg_state(a_state)
  );

  // memory model: waitrequest low after a_lat cycles of read (a_lat < 0: never)
  int          a_lat = 1;
  logic [31:0] a_key = 32'hDEADBEFF;
  int          a_wcnt = 0;
  assign a_s.waitrequest = !(a_s.read && a_lat >= 0 && a_wcnt == a_lat);
  assign a_s.readdata    = a_s.address ^ a_key;
  assign a_s.response    = a_s.address[8] ? 2'b10 : 2'b00;
  always @(posedge clk) begin
    if (!a_s.read || !a_s.waitrequest) a_wcnt <= 0;
    else a_wcnt <= a_wcnt + 1;
  end

  // ---------------- DUT Z (TIMEOUT = 0) ----------------
  progmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) z_m0 ();
  progmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) z_m1 ();
  progmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) z_s ();
  logic [1:0] z_state;

  progmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .m0(z_m0), .m1(z_m1), .s(z_s), .o_dbg_state(z_state)
  );

  int z_wcnt = 0;
  assign z_s.waitrequest = !(z_s.read && z_wcnt == 300);
  assign z_s.readdata    = z_s.address ^ 32'h12345678;
  assign z_s.response    = 2'b00;
  always @(posedge clk) begin
    if (!z_s.read || !z_s.waitrequest) z_wcnt <= 0;
    else z_wcnt <= z_wcnt + 1;
  end

  // expected result for an access issued to dut_a under the current model setting
  function automatic logic [33:0] model(input logic [31:0] addr);
    if (a_lat < 0 || a_lat >= 8) return {2'b10, 32'h0};
    return {(addr[8] ? 2'b10 : 2'b00), addr ^ a_key};
  endfunction

  // ---------------- requester drivers (dut_a) ----------------
  for (genvar g = 0; g < 2; g++) begin : gen_drv
    int abort_cnt = 0;
    int t_assert = 0;
    initial begin : drv
      req_t        r;
      logic [33:0] e;
      a_m[g].read = 1'b0;
      a_m[g].address = '0;
      forever begin
        @(negedge clk);
        if (!a_m[g].waitrequest) begin
          if (a_m[g].read) begin
            check_eq($sformatf("m%0d_expected_pending", g), exp_q[g].size() > 0, 1);
            if (exp_q[g].size() > 0) begin
              e = exp_q[g].pop_front();
              check_eq($sformatf("m%0d_readdata", g), a_m[g].readdata, e[31:0]);
              check_eq($sformatf("m%0d_response", g), a_m[g].response, e[33:32]);
            end
            lat_last[g] = cyc - t_assert;
            done_cnt[g]++;
            a_m[g].read = 1'b0;
          end else begin
            drop_cnt[g]++;
          end
        end
        if (a_m[g].read && abort_cnt > 0) begin
          abort_cnt--;
          if (abort_cnt == 0) begin
            a_m[g].address = ~a_m[g].address;
            a_m[g].read = 1'b0;
          end
        end else if (!a_m[g].read && req_q[g].size() > 0) begin
          r = req_q[g].pop_front();
          a_m[g].address = r.addr;
          a_m[g].read = 1'b1;
          t_assert = cyc;
          abort_cnt = int'(r.abort);
          if (r.abort == 8'd0) exp_q[g].push_back(model(r.addr));
        end
      end
    end
  end

  // ---------------- memory-side monitor (dut_a) ----------------
  initial begin : mon
    logic        prev_read;
    logic [31:0] prev_addr;
    int          cur_len;
    prev_read = 1'b0;
    prev_addr = '0;
    cur_len = 0;
    forever begin
      @(negedge clk);
      if (a_s.read) begin
        if (!prev_read) sa_log.push_back(a_s.address);
        else check_eq("s_address_stable", a_s.address, prev_addr);
        cur_len++;
      end else if (prev_read) begin
        len_log.push_back(cur_len);
        cur_len = 0;
      end
      prev_read = a_s.read;
      prev_addr = a_s.address;
      if (!a_m[0].waitrequest || !a_m[1].waitrequest)
        check_eq("wr_exclusive", {a_m[0].waitrequest, a_m[1].waitrequest}, 2'b01 ^ {1'b0, a_m[0].waitrequest} ^ {a_m[0].waitrequest, 1'b0});
    end
  end

  // ---------------- helpers ----------------
  task automatic push_req(input int m, input logic [31:0] addr, input int ab);
    req_t r;
    r.addr = addr;
    r.abort = 8'(ab);
    req_q[m].push_back(r);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !(req_q[0].size() == 0 && req_q[1].size() == 0 &&
                           exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                           !a_m[0].read && !a_m[1].read && a_state == 2'd0)) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_within_budget"}, n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // global time limit
  initial begin
    #500000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    int d1;
    int n;
    int nreq;
    int rd_cycles;
    rst_n = 1'b0;
    z_m0.read = 1'b0;
    z_m0.address = '0;
    z_m1.read = 1'b0;
    z_m1.address = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_read", a_s.read, 0);
    check_eq("rst_s_address", a_s.address, 0);
    check_eq("rst_m0_wait", a_m[0].waitrequest, 1);
    check_eq("rst_m1_wait", a_m[1].waitrequest, 1);
    check_eq("rst_m0_readdata", a_m[0].readdata, 0);
    check_eq("rst_m0_response", a_m[0].response, 0);
    check_eq("rst_state", a_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single m0 read, one memory wait cycle
    a_lat = 1;
    sa_log.delete();
    len_log.delete();
    push_req(0, 32'h10, 0);
    wait_idle("t1", 100);
    check_eq("t1_m0_done", done_cnt[0], 1);
    check_eq("t1_latency", lat_last[0], 3);
    check_eq("t1_s_read_len", len_log.size() > 0 ? len_log[0] : -1, 2);
    check_eq("t1_s_addr", sa_log.size() > 0 ? sa_log[0] : 32'hFFFF_FFFF, 32'h10);

    // both requesting continuously from reset
    do_reset();
    sa_log.delete();
    len_log.delete();
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    push_req(0, 32'h4, 0);
    push_req(0, 32'h4, 0);
    push_req(1, 32'h8, 0);
    push_req(1, 32'h8, 0);
    wait_idle("t2", 200);
    check_eq("t2_n_access", sa_log.size(), 4);
    for (int i = 0; i < 4 && i < sa_log.size(); i++)
      check_eq($sformatf("t2_order_%0d", i), sa_log[i], (i % 2 == 0) ? 32'h4 : 32'h8);
    check_eq("t2_m0_done", done_cnt[0] - d0, 2);
    check_eq("t2_m1_done", done_cnt[1] - d1, 2);

    // hung memory: timeout after 8 REQ cycles, then a normal m0 read
    a_lat = -1;
    len_log.delete();
    push_req(1, 32'h20, 0);
    wait_idle("t3", 100);
    check_eq("t3_s_read_len", len_log.size() > 0 ? len_log[0] : -1, 8);
    check_eq("t3_idle", a_state, 0);
    a_lat = 1;
    d0 = done_cnt[0];
    push_req(0, 32'h30, 0);
    wait_idle("t3b", 100);
    check_eq("t3b_m0_done", done_cnt[0] - d0, 1);

    // m0 changes address and drops read while its access is in flight
    a_lat = 3;
    sa_log.delete();
    len_log.delete();
    d0 = drop_cnt[0];
    d1 = done_cnt[1];
    push_req(0, 32'h40, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    push_req(1, 32'h50, 0);
    wait_idle("t4", 100);
    check_eq("t4_n_access", sa_log.size(), 2);
    check_eq("t4_first_addr", sa_log.size() > 0 ? sa_log[0] : 32'hFFFF_FFFF, 32'h40);
    check_eq("t4_second_addr", sa_log.size() > 1 ? sa_log[1] : 32'hFFFF_FFFF, 32'h50);
    check_eq("t4_first_len", len_log.size() > 0 ? len_log[0] : -1, 4);
    check_eq("t4_m0_dropped_resp", drop_cnt[0] - d0, 1);
    check_eq("t4_m1_done", done_cnt[1] - d1, 1);

    // reset during REQ with m1 granted; m0 must win the tie afterwards
    push_req(0, 32'h34, 0);
    wait_idle("t5a", 100);
    sa_log.delete();
    push_req(1, 32'h60, 0);
    push_req(0, 32'h70, 0);
    n = 0;
    while (n < 50 && !a_s.read) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_req_seen", n < 50, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_s_read", a_s.read, 0);
    check_eq("t5_async_m0_wait", a_m[0].waitrequest, 1);
    check_eq("t5_async_m1_wait", a_m[1].waitrequest, 1);
    check_eq("t5_async_state", a_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle("t5", 100);
    check_eq("t5_n_access", sa_log.size(), 3);
    check_eq("t5_pre_reset_grant", sa_log.size() > 0 ? sa_log[0] : 32'hFFFF_FFFF, 32'h60);
    check_eq("t5_post_reset_grant", sa_log.size() > 1 ? sa_log[1] : 32'hFFFF_FFFF, 32'h70);

    // random traffic from both requesters
    for (int b = 0; b < 3; b++) begin
      a_lat = $urandom_range(0, 5);
      sa_log.delete();
      nreq = $urandom_range(4, 8);
      for (int i = 0; i < nreq; i++)
        push_req($urandom_range(0, 1), 32'($urandom_range(0, 1023)), 0);
      wait_idle($sformatf("rnd%0d", b), 400);
      check_eq($sformatf("rnd%0d_n_access", b), sa_log.size(), nreq);
    end
    check_eq("m1_never_dropped", drop_cnt[1], 0);

    // TIMEOUT = 0: 300-cycle memory wait completes without error
    @(negedge clk);
    z_m0.address = 32'h0;
    z_m0.read = 1'b1;
    n = 0;
    rd_cycles = 0;
    while (n < 400 && z_m0.waitrequest) begin
      @(negedge clk);
      n++;
      if (z_s.read) rd_cycles++;
      if (!z_m1.waitrequest) check_eq("z_m1_wait", z_m1.waitrequest, 1);
    end
    check_eq("z_done", n < 400, 1);
    check_eq("z_readdata", z_m0.readdata, 32'h12345678);
    check_eq("z_response", z_m0.response, 2'b00);
    check_eq("z_s_read_len", rd_cycles, 301);
    z_m0.read = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("z_idle", z_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/progmem_arbiter.md
Name: progmem_arbiter

Overview:
- Shares the single read-only program memory port (Avalon-style address/read/readdata/response/waitrequest) between two requesters.
- m0 is the DSI command sequencer fetch and m1 is the host debug/readback path.
- Round-robin arbitration; one outstanding access at a time.
- Registered response path with a slave timeout that converts a hung slave access into an error response.

Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, read data width on all ports
- TIMEOUT, 255, max cycles waiting for s_waitrequest low before forcing an error; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  requester 0 address
- m0_read  in  1  requester 0 read request, held until m0_waitrequest low
- m0_readdata  out  DATA_W  requester 0 read data, valid when m0_waitrequest low
- m0_response  out  2  requester 0 response: 2'b00 OKAY, 2'b10 SLVERR
- m0_waitrequest  out  1  requester 0 stall; low for exactly one cycle per completed read
- m1_address, m1_read, m1_readdata, m1_response, m1_waitrequest: same as m0, for requester 1
- s_address  out  ADDR_W  address to program memory
- s_read  out  1  read strobe to program memory
- s_readdata  in  DATA_W  program memory data
- s_response  in  2  program memory response
- s_waitrequest  in  1  program memory stall; data is valid in the cycle it is low

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous active-low.
- Reset values:
  - state IDLE; s_read 0; s_address 0
  - m0/m1_waitrequest 1; readdata 0; response 0
  - last_grant = 1, so m0 wins the first tie
  - timeout counter 0
- States:
  - IDLE:
    - If no mN_read is high, stay in IDLE.
    - If exactly one is high, grant it.
    - If both are high, grant the one that is not last_grant.
    - On a grant, latch grant index and mN_address into s_address, clear the counter, go to REQ.
  - REQ:
    - s_read = 1; s_address stays stable.
    - If s_waitrequest = 0: capture s_readdata and s_response, set last_grant = grant, go to RESP.
    - Else if TIMEOUT != 0 and counter == TIMEOUT-1: capture readdata = 0 and response = 2'b10, set last_grant = grant, go to RESP.
    - Else: counter + 1.
  - RESP:
    - s_read = 0.
    - Granted mN_waitrequest = 0 for this one cycle; mN_readdata/mN_response carry the captured values.
    - Go to IDLE.
- Timing:
  - s_read is registered and driven only in REQ.
  - Master waitrequest/readdata/response are registered.
  - No combinational path from s_* to m*_*.
- Latency: request sampled in IDLE at cycle 0, s_read high at cycle 1. With a slave that drops waitrequest one cycle after read, capture happens at cycle 2 and the master completes at cycle 3.
  - Minimum of 4 cycles between back-to-back accesses, since IDLE is always revisited.
- Non-granted requester: waitrequest stays 1 throughout; its request remains pending.
- Fairness: with both requesting continuously, grants alternate m0, m1, m0, ...
- Requester deasserting read while granted (protocol violation):
  - The slave access runs to completion or timeout.
  - The RESP cycle still occurs and the result is dropped by the master.
  - The arbiter does not hang.
- Address change while granted: ignored; the latched address is used.
- Counter width: clog2(TIMEOUT+1), saturating. TIMEOUT = 1 means error after 1 REQ cycle without response.
- Reset mid-transaction: immediately returns to reset values; the in-flight slave read is abandoned because s_read drops asynchronously.

Test Plan:
- Single m0 read, addr 0x10, slave returns 0xDEADBEEF after 1 wait cycle -> s_read high cycles 1-2; m0_waitrequest low only at cycle 3 with readdata 0xDEADBEEF, response 0; m1_waitrequest stays 1.
- m0 and m1 both request continuously from reset (addr 0x4 / 0x8) -> slave sees 0x4, 0x8, 0x4, 0x8; each master completes every second transaction; no completion is lost.
- Slave holds waitrequest high forever, TIMEOUT = 8, m1 reads -> s_read high for exactly 8 cycles; m1 gets readdata 0, response 2'b10; arbiter back in IDLE; next m0 read completes normally.
- TIMEOUT = 0, slave waits 300 cycles then responds 0x12345678 -> no error; m0 receives 0x12345678, response 0.
- m0 granted, m0 changes address and drops read during REQ -> s_address unchanged; RESP cycle occurs; a subsequent m1 request is granted on the next IDLE.
- rst_n asserted during REQ -> s_read 0 and both waitrequests 1 asynchronously; after release, m0 wins the first tie.
